// File: rtl/mult_accum_stage.sv
// rtl/mult_accum_stage.sv - block accumulator behind an 8-stage pipelined signed multiplier
// Optional saturation selected by ACC_SAT_EN (adds the sat output port).
module mult_accum_stage #(
    parameter int PROD_W  = 19,
    parameter int ACC_W   = 27,
    parameter int LATENCY = 8,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  cnt_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
`ifdef ACC_SAT_EN
    output logic              sat,
`endif
    output logic              overrun
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [LATENCY-1:0] tag_v_q, tag_l_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_out_q, acc_out_d;
    logic [CNT_W-1:0]   cnt_out_q, cnt_out_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;

    logic               tv, tl;
    logic [ACC_W-1:0]   prod_ext, base_acc, sum;
    logic [CNT_W-1:0]   cnt_next;

    assign tv       = tag_v_q[LATENCY-1];
    assign tl       = tag_l_q[LATENCY-1];
    assign prod_ext = ACC_W'($signed(product));
    assign base_acc = (state_q == RUN) ? acc_q : '0;
    assign cnt_next = ((state_q == RUN) ? cnt_q : '0) + 1'b1;

`ifdef ACC_SAT_EN
    localparam logic signed [ACC_W:0] MAX_W = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_W = {2'b11, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_wide;
    logic                  blk_sat_q, blk_sat_d, sat_q, sat_d, hit, blk_sat_next;

    // sat flags any product that drove the running sum onto a rail.
    always_comb begin
        sum_wide = $signed({base_acc[ACC_W-1], base_acc}) + $signed({prod_ext[ACC_W-1], prod_ext});
        sum      = sum_wide[ACC_W-1:0];
        if (sum_wide > MAX_W)      sum = MAX_W[ACC_W-1:0];
        else if (sum_wide < MIN_W) sum = MIN_W[ACC_W-1:0];
        hit          = (sum_wide >= MAX_W) || (sum_wide <= MIN_W);
        blk_sat_next = ((state_q == RUN) && blk_sat_q) || hit;
    end
    assign sat = sat_q;
`else
    assign sum = base_acc + prod_ext;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_out_d   = acc_out_q;
        cnt_out_d   = cnt_out_q;
        out_valid_d = out_valid_q && !out_ready;
        overrun_d   = overrun_q;
`ifdef ACC_SAT_EN
        blk_sat_d   = blk_sat_q;
        sat_d       = sat_q;
`endif
        if (tv) begin
            if (tl) begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
`ifdef ACC_SAT_EN
                blk_sat_d = 1'b0;
`endif
                // Output register accepts when empty or being drained this cycle.
                if (!out_valid_q || out_ready) begin
                    acc_out_d   = sum;
                    cnt_out_d   = cnt_next;
                    out_valid_d = 1'b1;
`ifdef ACC_SAT_EN
                    sat_d       = blk_sat_next;
`endif
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                state_d = RUN;
                acc_d   = sum;
                cnt_d   = cnt_next;
`ifdef ACC_SAT_EN
                blk_sat_d = blk_sat_next;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tag_v_q     <= '0;
            tag_l_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_out_q   <= '0;
            cnt_out_q   <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef ACC_SAT_EN
            blk_sat_q   <= 1'b0;
            sat_q       <= 1'b0;
`endif
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_l_q[i] <= tag_l_q[i-1];
            end
            tag_v_q[0]  <= in_valid;
            tag_l_q[0]  <= in_valid && in_last;
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_out_q   <= acc_out_d;
            cnt_out_q   <= cnt_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
`ifdef ACC_SAT_EN
            blk_sat_q   <= blk_sat_d;
            sat_q       <= sat_d;
`endif
        end
    end

    assign acc_out   = acc_out_q;
    assign cnt_out   = cnt_out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == RUN) || (|tag_v_q);

endmodule
